// File: rtl/lcd_spi_multi_serializer.sv
// SPI mode-0 serializer that sends 8/16-bit words, MSB first, to one of NUM_LCDS panels sharing sclk/data/dc.
// Words to the same panel stream with CS held low. A panel switch or an empty input inserts a timed CS hold and gap.
module lcd_spi_multi_serializer #(
  parameter int NUM_LCDS = 4,
  parameter int SEL_W    = 2,
  parameter int CLK_DIV  = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic                mclk,
  input  logic                s00_axi_aresetn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [15:0]         cmd_data,
  input  logic                cmd_wide,
  input  logic                cmd_dc,
  input  logic [SEL_W-1:0]    cmd_sel,
  output logic                lcd_sclk,
  output logic                lcd_data,
  output logic                lcd_dc,
  output logic [NUM_LCDS-1:0] lcd_cs_n,
  output logic                busy
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LAST  = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, DONE, HOLD, GAP} state_t;

  state_t           state, state_nxt;
  logic [15:0]      shreg;
  logic [3:0]       bit_cnt;
  logic [7:0]       div_cnt;
  logic [7:0]       tmr;
  logic             sclk_q, data_q, dc_q;
  logic [SEL_W-1:0] sel_q;
  logic             ready_c, accept, sel_match, half_end, last_half, cs_on;

  always_ff @(posedge mclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready_c   = 1'b0;
    accept    = 1'b0;
    sel_match = (cmd_sel == sel_q);
    half_end  = (div_cnt == DIV_LAST);
    last_half = half_end && sclk_q && (bit_cnt == 4'd0);
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: if (last_half) state_nxt = DONE;
      // A same-panel word chains straight into SHIFT; a differing panel is refused here
      DONE: begin
        ready_c = sel_match;
        if (cmd_valid && sel_match) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end else if (CS_HOLD == 0) begin
          state_nxt = GAP;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD:    if (tmr == HOLD_LAST) state_nxt = GAP;
      GAP:     if (tmr == GAP_LAST)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
      dc_q    <= 1'b0;
      sel_q   <= '0;
    end else if (accept) begin
      div_cnt <= '0;
      sclk_q  <= 1'b0;
      dc_q    <= cmd_dc;
      sel_q   <= cmd_sel;
      if (cmd_wide) begin
        data_q  <= cmd_data[15];
        shreg   <= {cmd_data[14:0], 1'b0};
        bit_cnt <= 4'd15;
      end else begin
        data_q  <= cmd_data[7];
        shreg   <= {cmd_data[6:0], 9'd0};
        bit_cnt <= 4'd7;
      end
    end else if (state == SHIFT) begin
      if (!half_end) begin
        div_cnt <= div_cnt + 8'd1;
      end else begin
        div_cnt <= '0;
        sclk_q  <= !sclk_q;
        // Next bit appears only as sclk falls, keeping data stable through the high phase
        if (sclk_q && (bit_cnt != 4'd0)) begin
          data_q  <= shreg[15];
          shreg   <= {shreg[14:0], 1'b0};
          bit_cnt <= bit_cnt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn)                            tmr <= '0;
    else if (state_nxt != state)                     tmr <= '0;
    else if ((state == HOLD || state == GAP) && tmr != 8'hFF) tmr <= tmr + 8'd1;
  end

  assign cs_on = (state == SHIFT) || (state == DONE) || (state == HOLD);

  // Out-of-range selects match no index, so the word is clocked out with every CS high
  always_comb begin
    lcd_cs_n = '1;
    for (int i = 0; i < NUM_LCDS; i++) begin
      if (cs_on && (sel_q == SEL_W'(i))) lcd_cs_n[i] = 1'b0;
    end
  end

  assign lcd_sclk  = sclk_q;
  assign lcd_data  = data_q;
  assign lcd_dc    = (state == DONE && accept) ? cmd_dc : dc_q;
  assign busy      = (state != IDLE);
  assign cmd_ready = s00_axi_aresetn && ready_c;

endmodule

// File: tb/tb_lcd_spi_multi_serializer.sv
// Randomized bench for lcd_spi_multi_serializer: two instances (default and NUM_LCDS=1/CLK_DIV=1/CS_HOLD=0)
// traced cycle by cycle against a timeline model built from word lengths, hold and gap durations.
module tb_lcd_spi_multi_serializer;

  logic mclk = 1'b0;
  logic rstn;
  always #5 mclk = ~mclk;

  logic        a_valid, a_ready, a_wide, a_dc, a_sclk, a_mosi, a_lcd_dc, a_busy;
  logic [15:0] a_data;
  logic [1:0]  a_sel;
  logic [3:0]  a_cs;
  logic        b_valid, b_ready, b_wide, b_dc, b_sclk, b_mosi, b_lcd_dc, b_busy;
  logic [15:0] b_data;
  logic [0:0]  b_sel;
  logic [0:0]  b_cs;

  lcd_spi_multi_serializer #(.NUM_LCDS(4), .SEL_W(2), .CLK_DIV(2), .CS_HOLD(2), .CS_GAP(2)) dut_a (
    .mclk(mclk), .s00_axi_aresetn(rstn), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_data(a_data), .cmd_wide(a_wide), .cmd_dc(a_dc), .cmd_sel(a_sel),
    .lcd_sclk(a_sclk), .lcd_data(a_mosi), .lcd_dc(a_lcd_dc), .lcd_cs_n(a_cs), .busy(a_busy));

  lcd_spi_multi_serializer #(.NUM_LCDS(1), .SEL_W(1), .CLK_DIV(1), .CS_HOLD(0), .CS_GAP(2)) dut_b (
    .mclk(mclk), .s00_axi_aresetn(rstn), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_data(b_data), .cmd_wide(b_wide), .cmd_dc(b_dc), .cmd_sel(b_sel),
    .lcd_sclk(b_sclk), .lcd_data(b_mosi), .lcd_dc(b_lcd_dc), .lcd_cs_n(b_cs), .busy(b_busy));

  int total = 0;
  int bad   = 0;

  logic [15:0] w_data [0:7];
  logic        w_wide [0:7];
  logic        w_dc   [0:7];
  logic [3:0]  w_sel  [0:7];
  int          n_words;

  // Trace word layout: {sclk, data, dc, busy, ready, cs_n[15:0]}
  logic [20:0] tr [0:1023];
  logic [20:0] ex [0:1023];
  logic [31:0] exp_bits;
  logic        hold_data [0:1];
  logic        hold_dc   [0:1];

  function automatic logic [15:0] csm(input logic [3:0] sel, input int nl);
    logic [15:0] m;
    m = '1;
    if (int'(sel) < nl) m[sel] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] cap(input int n);
    logic [31:0] v;
    v = '0;
    for (int c = 1; c < n; c++)
      if (!tr[c-1][20] && tr[c][20]) v = {v[30:0], tr[c][19]};
    return v;
  endfunction

  task automatic sample(input int which, input int c);
    if (which == 0) tr[c] = {a_sclk, a_mosi, a_lcd_dc, a_busy, a_ready, 12'hFFF, a_cs};
    else            tr[c] = {b_sclk, b_mosi, b_lcd_dc, b_busy, b_ready, 15'h7FFF, b_cs};
  endtask

  task automatic drive(input int which, input int idx);
    if (which == 0) begin
      a_valid = 1'b1; a_data = w_data[idx]; a_wide = w_wide[idx]; a_dc = w_dc[idx]; a_sel = w_sel[idx][1:0];
    end else begin
      b_valid = 1'b1; b_data = w_data[idx]; b_wide = w_wide[idx]; b_dc = w_dc[idx]; b_sel = w_sel[idx][0:0];
    end
  endtask

  task automatic run_seq(input int which, input int ncyc);
    int   idx;
    logic acc;
    idx = 0;
    drive(which, 0);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge mclk);
      sample(which, c);
      acc = (which == 0) ? (a_valid && a_ready) : (b_valid && b_ready);
      @(posedge mclk); #1;
      if (acc) begin
        idx++;
        if (idx < n_words)    drive(which, idx);
        else if (which == 0)  a_valid = 1'b0;
        else                  b_valid = 1'b0;
      end
    end
  endtask

  // Timeline model: each word occupies 2*div*nbits shift cycles plus one DONE cycle; a panel
  // change or end of input adds hold, gap and one idle accept cycle before the next word.
  task automatic build(input int which, output int ncyc);
    int          dv, hl, nl, t, c, nb, s, d;
    logic        same, b0, dcl;
    logic [3:0]  nxt;
    logic [15:0] m;
    dv = (which == 0) ? 2 : 1;
    hl = (which == 0) ? 2 : 0;
    nl = (which == 0) ? 4 : 1;
    b0 = hold_data[which];
    dcl = hold_dc[which];
    exp_bits = '0;
    ex[0] = {1'b0, b0, dcl, 1'b0, 1'b1, 16'hFFFF};
    t = 1;
    c = 1;
    for (int i = 0; i < n_words; i++) begin
      nb = w_wide[i] ? 16 : 8;
      s  = 2 * dv * nb;
      m  = csm(w_sel[i], nl);
      exp_bits = w_wide[i] ? {exp_bits[15:0], w_data[i]} : {exp_bits[23:0], w_data[i][7:0]};
      for (int k = 0; k < s; k++)
        ex[t+k] = {(k % (2*dv)) >= dv, w_data[i][nb-1-k/(2*dv)], w_dc[i], 1'b1, 1'b0, m};
      b0   = w_data[i][0];
      dcl  = w_dc[i];
      d    = t + s;
      same = (i + 1 < n_words) && (w_sel[i+1] == w_sel[i]);
      nxt  = (i + 1 < n_words) ? w_sel[i+1] : w_sel[i];
      ex[d] = {1'b0, b0, same ? w_dc[i+1] : dcl, 1'b1, nxt == w_sel[i], m};
      c = d + 1;
      if (same) begin
        t = c;
      end else begin
        for (int h = 0; h < hl; h++) begin ex[c] = {1'b0, b0, dcl, 1'b1, 1'b0, m}; c++; end
        for (int g = 0; g < 2; g++)  begin ex[c] = {1'b0, b0, dcl, 1'b1, 1'b0, 16'hFFFF}; c++; end
        ex[c] = {1'b0, b0, dcl, 1'b0, 1'b1, 16'hFFFF};
        c++;
        t = c;
      end
    end
    ex[c]   = {1'b0, b0, dcl, 1'b0, 1'b1, 16'hFFFF};
    ex[c+1] = {1'b0, b0, dcl, 1'b0, 1'b1, 16'hFFFF};
    ncyc = c + 2;
    hold_data[which] = b0;
    hold_dc[which]   = dcl;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    @(negedge mclk);
    sample(0, 0);
    sample(1, 1);
    total++; if (tr[0] !== {5'b0, 16'hFFFF}) begin bad++; $display("[TB] FAIL reset_a got=%h want=%h", tr[0], {5'b0, 16'hFFFF}); end
    total++; if (tr[1] !== {5'b0, 16'hFFFF}) begin bad++; $display("[TB] FAIL reset_b got=%h want=%h", tr[1], {5'b0, 16'hFFFF}); end
    @(posedge mclk); #1;
    rstn = 1'b1;
    hold_data[0] = 1'b0; hold_data[1] = 1'b0; hold_dc[0] = 1'b0; hold_dc[1] = 1'b0;
    repeat (2) begin @(posedge mclk); #1; end
    @(negedge mclk);
    total++; if ({a_ready, a_busy} !== 2'b10) begin bad++; $display("[TB] FAIL reset_release got=%b want=10", {a_ready, a_busy}); end
    @(posedge mclk); #1;
  endtask

  task automatic test_single_word();
    int n;
    for (int r = 0; r < 5; r++) begin
      n_words = 1;
      if (r == 0) begin
        w_data[0] = 16'h00A5; w_wide[0] = 1'b0; w_dc[0] = 1'b1; w_sel[0] = 4'd2;
      end else begin
        w_data[0] = 16'($urandom); w_wide[0] = 1'($urandom); w_dc[0] = 1'($urandom); w_sel[0] = 4'($urandom_range(0, 3));
      end
      build(0, n);
      run_seq(0, n);
      for (int c = 0; c < n; c++) begin
        total++; if (tr[c] !== ex[c]) begin bad++; $display("[TB] FAIL single r=%0d cyc=%0d got=%h want=%h", r, c, tr[c], ex[c]); end
      end
      total++; if (cap(n) !== exp_bits) begin bad++; $display("[TB] FAIL single_bits got=%h want=%h", cap(n), exp_bits); end
      if (r == 0) begin
        total++; if (tr[35][3:0] !== 4'b1011) begin bad++; $display("[TB] FAIL a5_cs35 got=%b want=1011", tr[35][3:0]); end
        total++; if (tr[36][3:0] !== 4'b1111) begin bad++; $display("[TB] FAIL a5_cs36 got=%b want=1111", tr[36][3:0]); end
        total++; if (tr[38][16] !== 1'b1)     begin bad++; $display("[TB] FAIL a5_ready38 got=%b want=1", tr[38][16]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n_words = 2;
    w_data[0] = 16'h1234; w_wide[0] = 1'b1; w_dc[0] = 1'b0; w_sel[0] = 4'd0;
    w_data[1] = 16'hABCD; w_wide[1] = 1'b1; w_dc[1] = 1'b0; w_sel[1] = 4'd0;
    build(0, n);
    run_seq(0, n);
    for (int c = 0; c < n; c++) begin
      total++; if (tr[c] !== ex[c]) begin bad++; $display("[TB] FAIL b2b cyc=%0d got=%h want=%h", c, tr[c], ex[c]); end
    end
    total++; if (cap(n) !== 32'h1234ABCD) begin bad++; $display("[TB] FAIL b2b_bits got=%h want=1234abcd", cap(n)); end
    total++; if (tr[65][16] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready65 got=%b want=1", tr[65][16]); end
  endtask

  task automatic test_dc_change();
    int n, changes, first;
    n_words = 2;
    w_sel[0] = 4'($urandom_range(0, 3));
    w_data[0] = 16'h002A; w_wide[0] = 1'b0; w_dc[0] = 1'b0;
    w_data[1] = 16'h0000; w_wide[1] = 1'b0; w_dc[1] = 1'b1; w_sel[1] = w_sel[0];
    build(0, n);
    run_seq(0, n);
    for (int c = 0; c < n; c++) begin
      total++; if (tr[c] !== ex[c]) begin bad++; $display("[TB] FAIL dc cyc=%0d got=%h want=%h", c, tr[c], ex[c]); end
    end
    changes = 0;
    first = -1;
    for (int c = 2; c < n; c++)
      if (tr[c][18] !== tr[c-1][18]) begin changes++; if (first < 0) first = c; end
    total++; if (changes !== 1 || first !== 33) begin bad++; $display("[TB] FAIL dc_edge got=%0d@%0d want=1@33", changes, first); end
    total++; if (tr[33][20] !== 1'b0) begin bad++; $display("[TB] FAIL dc_sclk got=%b want=0", tr[33][20]); end
  endtask

  task automatic test_channel_change();
    int n, multi, last1, first3;
    n_words = 2;
    w_data[0] = 16'($urandom); w_wide[0] = 1'($urandom); w_dc[0] = 1'($urandom); w_sel[0] = 4'd1;
    w_data[1] = 16'($urandom); w_wide[1] = 1'($urandom); w_dc[1] = 1'($urandom); w_sel[1] = 4'd3;
    build(0, n);
    run_seq(0, n);
    multi = 0;
    last1 = -1;
    first3 = -1;
    for (int c = 0; c < n; c++) begin
      total++; if (tr[c] !== ex[c]) begin bad++; $display("[TB] FAIL chan cyc=%0d got=%h want=%h", c, tr[c], ex[c]); end
      if ($countones(~tr[c][3:0]) > 1) multi++;
      if (!tr[c][1]) last1 = c;
      if (!tr[c][3] && first3 < 0) first3 = c;
    end
    total++; if (multi !== 0) begin bad++; $display("[TB] FAIL chan_multi_cs got=%0d want=0", multi); end
    total++; if (first3 - last1 - 1 !== 3) begin bad++; $display("[TB] FAIL chan_gap got=%0d want=3", first3 - last1 - 1); end
  endtask

  task automatic test_random_seq();
    int n;
    for (int r = 0; r < 6; r++) begin
      n_words = $urandom_range(1, 4);
      for (int i = 0; i < n_words; i++) begin
        w_data[i] = 16'($urandom); w_wide[i] = 1'($urandom); w_dc[i] = 1'($urandom);
        w_sel[i] = (i > 0 && $urandom_range(0, 1) == 1) ? w_sel[i-1] : 4'($urandom_range(0, 3));
      end
      build(0, n);
      run_seq(0, n);
      for (int c = 0; c < n; c++) begin
        total++; if (tr[c] !== ex[c]) begin bad++; $display("[TB] FAIL rand r=%0d cyc=%0d got=%h want=%h", r, c, tr[c], ex[c]); end
      end
      total++; if (cap(n) !== exp_bits) begin bad++; $display("[TB] FAIL rand_bits r=%0d got=%h want=%h", r, cap(n), exp_bits); end
    end
  endtask

  task automatic test_reset_mid_word();
    int          n;
    logic [15:0] m;
    n_words = 1;
    w_data[0] = 16'($urandom); w_wide[0] = 1'b1; w_dc[0] = 1'b1; w_sel[0] = 4'($urandom_range(0, 3));
    m = csm(w_sel[0], 4);
    drive(0, 0);
    @(posedge mclk); #1;
    a_valid = 1'b0;
    repeat (9) begin @(posedge mclk); #1; end
    total++; if ({a_busy, a_cs} !== {1'b1, m[3:0]}) begin bad++; $display("[TB] FAIL midrst_pre got=%b want=%b", {a_busy, a_cs}, {1'b1, m[3:0]}); end
    rstn = 1'b0;
    #1;
    sample(0, 0);
    total++; if (tr[0] !== {5'b0, 16'hFFFF}) begin bad++; $display("[TB] FAIL midrst got=%h want=%h", tr[0], {5'b0, 16'hFFFF}); end
    @(posedge mclk); #1;
    rstn = 1'b1;
    hold_data[0] = 1'b0; hold_data[1] = 1'b0; hold_dc[0] = 1'b0; hold_dc[1] = 1'b0;
    @(posedge mclk); #1;
    w_data[0] = 16'($urandom); w_dc[0] = 1'($urandom);
    build(0, n);
    run_seq(0, n);
    for (int c = 0; c < n; c++) begin
      total++; if (tr[c] !== ex[c]) begin bad++; $display("[TB] FAIL midrst_after cyc=%0d got=%h want=%h", c, tr[c], ex[c]); end
    end
    total++; if (cap(n) !== exp_bits) begin bad++; $display("[TB] FAIL midrst_bits got=%h want=%h", cap(n), exp_bits); end
  endtask

  task automatic test_sweep();
    int n, lows;
    for (int r = 0; r < 5; r++) begin
      if (r < 2) begin
        n_words = 1;
        w_data[0] = 16'($urandom); w_wide[0] = 1'b0; w_dc[0] = 1'($urandom); w_sel[0] = 4'(r);
      end else begin
        n_words = $urandom_range(1, 3);
        for (int i = 0; i < n_words; i++) begin
          w_data[i] = 16'($urandom); w_wide[i] = 1'($urandom); w_dc[i] = 1'($urandom); w_sel[i] = 4'($urandom_range(0, 1));
        end
      end
      build(1, n);
      run_seq(1, n);
      lows = 0;
      for (int c = 0; c < n; c++) begin
        total++; if (tr[c] !== ex[c]) begin bad++; $display("[TB] FAIL sweep r=%0d cyc=%0d got=%h want=%h", r, c, tr[c], ex[c]); end
        if (!tr[c][0]) lows++;
      end
      total++; if (cap(n) !== exp_bits) begin bad++; $display("[TB] FAIL sweep_bits r=%0d got=%h want=%h", r, cap(n), exp_bits); end
      if (r == 0) begin
        total++; if ({tr[16][20], tr[17][20], tr[17][0], tr[18][0], tr[18][17]} !== 5'b10011) begin
          bad++; $display("[TB] FAIL sweep_timing got=%b want=10011", {tr[16][20], tr[17][20], tr[17][0], tr[18][0], tr[18][17]});
        end
        total++; if (tr[20][16] !== 1'b1) begin bad++; $display("[TB] FAIL sweep_ready20 got=%b want=1", tr[20][16]); end
      end
      if (r == 1) begin
        total++; if (lows !== 0) begin bad++; $display("[TB] FAIL sweep_oor_cs got=%0d want=0", lows); end
      end
    end
  endtask

  initial begin
    a_valid = 1'b0; a_data = '0; a_wide = 1'b0; a_dc = 1'b0; a_sel = '0;
    b_valid = 1'b0; b_data = '0; b_wide = 1'b0; b_dc = 1'b0; b_sel = '0;
    rstn = 1'b0;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_dc_change();
    test_channel_change();
    test_random_seq();
    test_reset_mid_word();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
